// File: rtl/sbox_cfg_loader_pkg.sv
// ----------------------------------------------------------------------------
// sbox_cfg_pkg
// Shared constants and types for the switch-box configuration loader:
//   - route entry layout and side codes
//   - loader FSM state encoding
//   - reject-reason codes
//   - frame length constants
// No ports (package).
// ----------------------------------------------------------------------------
package sbox_cfg_pkg;

    // Route entry: source wire index in the upper half, source side in the lower.
    typedef struct packed {
        logic [2:0] idx;
        logic [2:0] side;
    } entry_t;

    localparam logic [2:0] SIDE_OFF    = 3'd0;
    localparam logic [2:0] SIDE_TOP    = 3'd1;
    localparam logic [2:0] SIDE_RIGHT  = 3'd2;
    localparam logic [2:0] SIDE_BOTTOM = 3'd3;
    localparam logic [2:0] SIDE_LEFT   = 3'd4;

    localparam logic [1:0] ST_HUNT  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_EVAL  = 2'd3;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_CKSUM = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;

    localparam int PAYLOAD_BITS = 108;
    localparam int CKSUM_BITS   = 6;

endpackage

// File: rtl/sbox_cfg_loader_if.sv
// ----------------------------------------------------------------------------
// sbox_cfg_loader_if
// Bundle between the fabric configuration controller (master) and the loader
// (slave).
//   cfg_din/cfg_valid/cfg_abort : serial frame stream, controller -> loader
//   cfg_top/bottom/left/right   : committed route entries, loader -> switch box
//   busy/done/err/err_code      : loader status, loader -> controller
// ----------------------------------------------------------------------------
interface sbox_cfg_loader_if #(
    parameter int N_TB = 5,
    parameter int N_LR = 4
);
    logic                  cfg_din;
    logic                  cfg_valid;
    logic                  cfg_abort;
    logic [N_TB*6-1:0]     cfg_top;
    logic [N_TB*6-1:0]     cfg_bottom;
    logic [N_LR*6-1:0]     cfg_left;
    logic [N_LR*6-1:0]     cfg_right;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [1:0]            err_code;

    modport master (
        output cfg_din, cfg_valid, cfg_abort,
        input  cfg_top, cfg_bottom, cfg_left, cfg_right,
        input  busy, done, err, err_code
    );

    modport slave (
        input  cfg_din, cfg_valid, cfg_abort,
        output cfg_top, cfg_bottom, cfg_left, cfg_right,
        output busy, done, err, err_code
    );
endinterface

// File: rtl/sbox_cfg_loader_entry_check.sv
// ----------------------------------------------------------------------------
// sbox_entry_check
// Combinational legality check of one 6-bit route entry.
//   i_entry : {idx[2:0], side[2:0]}
//   o_legal : 1 when the index exists on the named side (side OFF always legal)
// ----------------------------------------------------------------------------
module sbox_entry_check
    import sbox_cfg_pkg::*;
#(
    parameter int N_TB = 5,
    parameter int N_LR = 4
) (
    input  logic [5:0] i_entry,
    output logic       o_legal
);
    entry_t w_e;
    assign w_e = i_entry;

    always_comb begin
        o_legal = 1'b0;
        case (w_e.side)
            SIDE_OFF:                o_legal = 1'b1;
            SIDE_TOP,  SIDE_BOTTOM:  o_legal = (w_e.idx <= 3'(N_TB - 1));
            SIDE_RIGHT, SIDE_LEFT:   o_legal = (w_e.idx <= 3'(N_LR - 1));
            default:                 o_legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/sbox_cfg_loader.sv
// ----------------------------------------------------------------------------
// sbox_cfg_loader
// Serial configuration writer for a 5/5/4/4 switch box. Hunts for a sync word,
// shifts a payload of route entries into a shadow, shifts a checksum, then in
// one EVAL cycle validates and either commits the whole shadow or rejects it.
//   clk, rst : clock, synchronous active-high reset
//   bus      : sbox_cfg_loader_if.slave (stream in, config + status out)
// ----------------------------------------------------------------------------
module sbox_cfg_loader
    import sbox_cfg_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD = 8'hA5,
    parameter int         N_TB      = 5,
    parameter int         N_LR      = 4,
    parameter int         ENTRY_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    sbox_cfg_loader_if.slave bus
);
    localparam int N_ENT = 2 * N_TB + 2 * N_LR;
    localparam int PAY_W = N_ENT * ENTRY_W;

    logic [1:0]                          r_state;
    logic [7:0]                          r_win;
    logic [6:0]                          r_bitcnt;
    logic [PAY_W-1:0]                    r_shadow;
    logic [CKSUM_BITS-1:0]               r_cksum;
    logic [N_ENT-1:0][ENTRY_W-1:0]       r_active;
    logic                                r_done;
    logic                                r_err;
    logic [1:0]                          r_err_code;

    logic [7:0]                          w_win_nxt;
    logic [N_ENT-1:0][ENTRY_W-1:0]       w_ent;
    logic [N_ENT-1:0]                    w_legal;
    logic [ENTRY_W-1:0]                  w_xor;
    logic                                w_cks_ok;
    logic                                w_rng_ok;
    logic [6:0]                          w_cnt_inc;
    logic [N_TB*ENTRY_W-1:0]             w_top;
    logic [N_TB*ENTRY_W-1:0]             w_bottom;
    logic [N_LR*ENTRY_W-1:0]             w_left;
    logic [N_LR*ENTRY_W-1:0]             w_right;

    assign w_win_nxt = {r_win[6:0], bus.cfg_din};
    // Counter holds at all-ones rather than wrapping.
    assign w_cnt_inc = (r_bitcnt == 7'h7F) ? r_bitcnt : r_bitcnt + 7'd1;

    // First entry shifted in ends up in the top bits of the shadow.
    always_comb begin
        w_ent = '0;
        w_xor = '0;
        for (int k = 0; k < N_ENT; k++) begin
            w_ent[k] = r_shadow[PAY_W-1-ENTRY_W*k -: ENTRY_W];
            w_xor    = w_xor ^ w_ent[k];
        end
    end

    for (genvar k = 0; k < N_ENT; k++) begin : g_chk
        sbox_entry_check #(.N_TB(N_TB), .N_LR(N_LR)) u_chk (
            .i_entry (w_ent[k]),
            .o_legal (w_legal[k])
        );
    end

    assign w_cks_ok = (w_xor == r_cksum);
    assign w_rng_ok = &w_legal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_HUNT;
            r_win      <= '0;
            r_bitcnt   <= '0;
            r_shadow   <= '0;
            r_cksum    <= '0;
            r_active   <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_HUNT: begin
                    if (bus.cfg_abort) begin
                        r_win <= '0;
                    end else if (bus.cfg_valid) begin
                        if (w_win_nxt == SYNC_WORD) begin
                            // Start the next hunt from an empty window.
                            r_state  <= ST_LOAD;
                            r_win    <= '0;
                            r_bitcnt <= '0;
                        end else begin
                            r_win <= w_win_nxt;
                        end
                    end
                end
                ST_LOAD: begin
                    if (bus.cfg_abort) begin
                        r_state  <= ST_HUNT;
                        r_bitcnt <= '0;
                        r_shadow <= '0;
                    end else if (bus.cfg_valid) begin
                        r_shadow <= {r_shadow[PAY_W-2:0], bus.cfg_din};
                        if (r_bitcnt == 7'(PAY_W - 1)) begin
                            r_state  <= ST_CHECK;
                            r_bitcnt <= '0;
                        end else begin
                            r_bitcnt <= w_cnt_inc;
                        end
                    end
                end
                ST_CHECK: begin
                    if (bus.cfg_abort) begin
                        r_state  <= ST_HUNT;
                        r_bitcnt <= '0;
                        r_shadow <= '0;
                        r_cksum  <= '0;
                    end else if (bus.cfg_valid) begin
                        r_cksum <= {r_cksum[CKSUM_BITS-2:0], bus.cfg_din};
                        if (r_bitcnt == 7'(CKSUM_BITS - 1)) begin
                            r_state  <= ST_EVAL;
                            r_bitcnt <= '0;
                        end else begin
                            r_bitcnt <= w_cnt_inc;
                        end
                    end
                end
                ST_EVAL: begin
                    // Single cycle; valid and abort are not looked at here.
                    if (w_cks_ok && w_rng_ok) begin
                        r_active   <= w_ent;
                        r_done     <= 1'b1;
                        r_err_code <= ERR_NONE;
                    end else begin
                        r_err      <= 1'b1;
                        r_err_code <= (w_cks_ok ? ERR_NONE : ERR_CKSUM) |
                                      (w_rng_ok ? ERR_NONE : ERR_RANGE);
                    end
                    r_state  <= ST_HUNT;
                    r_shadow <= '0;
                    r_cksum  <= '0;
                end
                default: r_state <= ST_HUNT;
            endcase
        end
    end

    always_comb begin
        w_top    = '0;
        w_bottom = '0;
        w_left   = '0;
        w_right  = '0;
        for (int i = 0; i < N_TB; i++) begin
            w_top[ENTRY_W*i +: ENTRY_W]    = r_active[i];
            w_bottom[ENTRY_W*i +: ENTRY_W] = r_active[N_TB+i];
        end
        for (int i = 0; i < N_LR; i++) begin
            w_left[ENTRY_W*i +: ENTRY_W]   = r_active[2*N_TB+i];
            w_right[ENTRY_W*i +: ENTRY_W]  = r_active[2*N_TB+N_LR+i];
        end
    end

    assign bus.cfg_top    = w_top;
    assign bus.cfg_bottom = w_bottom;
    assign bus.cfg_left   = w_left;
    assign bus.cfg_right  = w_right;
    assign bus.busy       = (r_state != ST_HUNT);
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.err_code   = r_err_code;
endmodule

// File: tb/tb_sbox_cfg_loader.sv
// ----------------------------------------------------------------------------
// tb_sbox_cfg_loader
// Drives framed bitstreams into sbox_cfg_loader and compares status and
// committed configuration against a frame-level reference model.
// ----------------------------------------------------------------------------
module tb_sbox_cfg_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sbox_cfg_loader_if #(.N_TB(5), .N_LR(4)) bus_if ();

    sbox_cfg_loader #(.SYNC_WORD(8'hA5), .N_TB(5), .N_LR(4), .ENTRY_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // Model state: currently committed entries, and the frame being sent.
    // Entry order: top0..4, bottom0..4, left0..3, right0..3.
    logic [5:0] cur [18];
    logic [5:0] ent [18];
    logic [5:0] cks;

    // Observations around a frame end.
    logic         o_d1, o_e1, o_b1, o_d2, o_e2, o_d3, o_e3;
    logic [1:0]   o_code, o_code3;
    logic [107:0] o_cfg;

    function automatic bit legal(input logic [5:0] e);
        int side = int'(e[2:0]);
        int idx  = int'(e[5:3]);
        case (side)
            0:       return 1'b1;
            1, 3:    return idx < 5;
            2, 4:    return idx < 4;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [5:0] xor_all();
        logic [5:0] x = '0;
        for (int k = 0; k < 18; k++) x ^= ent[k];
        return x;
    endfunction

    function automatic logic [107:0] flat_cur();
        logic [29:0] t, b;
        logic [23:0] l, r;
        for (int i = 0; i < 5; i++) begin
            t[6*i +: 6] = cur[i];
            b[6*i +: 6] = cur[5+i];
        end
        for (int i = 0; i < 4; i++) begin
            l[6*i +: 6] = cur[10+i];
            r[6*i +: 6] = cur[14+i];
        end
        return {t, b, l, r};
    endfunction

    function automatic logic [107:0] dut_cfg();
        return {bus_if.cfg_top, bus_if.cfg_bottom, bus_if.cfg_left, bus_if.cfg_right};
    endfunction

    function automatic bit pick_gap(input int mode);
        if (mode == 1) return 1'b1;
        if (mode == 2) return $urandom_range(0, 3) == 0;
        return 1'b0;
    endfunction

    // Model outcome of the frame in ent/cks; updates cur on a commit.
    task automatic predict(output bit ok, output logic [1:0] code);
        bit rng = 1'b1;
        for (int k = 0; k < 18; k++) if (!legal(ent[k])) rng = 1'b0;
        code = {~rng, (xor_all() != cks)};
        ok   = (code == 2'b00);
        if (ok) cur = ent;
    endtask

    task automatic clear_frame();
        for (int k = 0; k < 18; k++) ent[k] = '0;
        cks = '0;
    endtask

    function automatic logic [5:0] rand_legal();
        int side = $urandom_range(0, 4);
        int idx;
        if (side == 0)                    idx = $urandom_range(0, 7);
        else if (side == 1 || side == 3)  idx = $urandom_range(0, 4);
        else                              idx = $urandom_range(0, 3);
        return {3'(idx), 3'(side)};
    endfunction

    task automatic drive_bit(input logic b, input bit gap);
        if (gap) begin
            @(negedge clk);
            bus_if.cfg_valid = 1'b0;
            bus_if.cfg_din   = 1'($urandom);
        end
        @(negedge clk);
        bus_if.cfg_din   = b;
        bus_if.cfg_valid = 1'b1;
    endtask

    task automatic send_head(input int gmode, input int npay);
        logic [7:0] s = 8'hA5;
        for (int i = 7; i >= 0; i--) drive_bit(s[i], pick_gap(gmode));
        for (int n = 0; n < npay; n++) drive_bit(ent[n/6][5 - n%6], pick_gap(gmode));
    endtask

    task automatic send_frame(input int gmode);
        send_head(gmode, 108);
        for (int i = 5; i >= 0; i--) drive_bit(cks[i], pick_gap(gmode));
    endtask

    // Samples the cycle after the last checksum bit, the pulse cycle, and one after.
    task automatic observe(input bit abort_eval);
        @(negedge clk);
        o_d1 = bus_if.done; o_e1 = bus_if.err; o_b1 = bus_if.busy;
        bus_if.cfg_valid = 1'($urandom);
        bus_if.cfg_din   = 1'($urandom);
        bus_if.cfg_abort = abort_eval;
        @(negedge clk);
        bus_if.cfg_valid = 1'b0;
        bus_if.cfg_abort = 1'b0;
        o_d2 = bus_if.done; o_e2 = bus_if.err; o_code = bus_if.err_code; o_cfg = dut_cfg();
        @(negedge clk);
        o_d3 = bus_if.done; o_e3 = bus_if.err; o_code3 = bus_if.err_code;
    endtask

    task automatic test_reset();
        bus_if.cfg_din = 1'b0; bus_if.cfg_valid = 1'b1; bus_if.cfg_abort = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < 18; k++) cur[k] = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_if.busy, bus_if.done, bus_if.err, bus_if.err_code} !== 5'b0 || dut_cfg() !== 108'b0) begin
            errors++;
            $display("FAIL reset_state busy/done/err/code=%b cfg=%h required 0", {bus_if.busy, bus_if.done, bus_if.err, bus_if.err_code}, dut_cfg());
        end
        bus_if.cfg_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero_frame();
        bit ok; logic [1:0] code;
        clear_frame();
        predict(ok, code);
        send_frame(0); observe(0);
        checks++;
        if ({o_b1, o_d1, o_e1, o_d2, o_e2, o_d3, o_e3} !== {3'b100, ok, !ok, 2'b00}) begin
            errors++;
            $display("FAIL zero_timing busy1,d1,e1,d2,e2,d3,e3=%b required %b", {o_b1, o_d1, o_e1, o_d2, o_e2, o_d3, o_e3}, {3'b100, ok, !ok, 2'b00});
        end
        checks++;
        if (o_code !== code || o_cfg !== flat_cur()) begin
            errors++;
            $display("FAIL zero_result code=%b cfg=%h required %b %h", o_code, o_cfg, code, flat_cur());
        end
    endtask

    task automatic test_single_and_bad_cksum();
        bit ok; logic [1:0] code;
        clear_frame();
        ent[0] = 6'b001_011; cks = 6'b001011;
        predict(ok, code);
        send_frame(0); observe(0);
        checks++;
        if ({o_d2, o_e2, o_code} !== {ok, !ok, code} || o_cfg !== flat_cur() || o_cfg[107:78] !== 30'h0B) begin
            errors++;
            $display("FAIL single_route d,e,code=%b cfg=%h required %b %h", {o_d2, o_e2, o_code}, o_cfg, {ok, !ok, code}, flat_cur());
        end
        cks = 6'b000000;
        predict(ok, code);
        send_frame(0); observe(0);
        checks++;
        if ({o_d2, o_e2, o_code, o_code3} !== {ok, !ok, code, code} || code !== 2'b01) begin
            errors++;
            $display("FAIL bad_cksum d,e,code,code_hold=%b required %b", {o_d2, o_e2, o_code, o_code3}, {ok, !ok, code, code});
        end
        checks++;
        if (o_cfg !== flat_cur()) begin
            errors++;
            $display("FAIL bad_cksum_hold cfg=%h required %h", o_cfg, flat_cur());
        end
    endtask

    task automatic test_range();
        bit ok; logic [1:0] code;
        for (int t = 0; t < 2; t++) begin
            clear_frame();
            if (t == 0) ent[12] = 6'b100_010; else ent[1] = 6'b000_101;
            cks = xor_all();
            predict(ok, code);
            send_frame(0); observe(0);
            checks++;
            if ({o_d2, o_e2, o_code, o_d3, o_e3} !== {ok, !ok, code, 2'b00} || code !== 2'b10) begin
                errors++;
                $display("FAIL range_%0d d,e,code,d3,e3=%b required %b", t, {o_d2, o_e2, o_code, o_d3, o_e3}, {ok, !ok, code, 2'b00});
            end
            checks++;
            if (o_cfg !== flat_cur()) begin
                errors++;
                $display("FAIL range_hold_%0d cfg=%h required %h", t, o_cfg, flat_cur());
            end
        end
    endtask

    task automatic test_gaps();
        bit ok; logic [1:0] code;
        logic [3:0] pre = 4'b1010;
        for (int k = 0; k < 18; k++) ent[k] = rand_legal();
        cks = xor_all();
        predict(ok, code);
        // Prefix overlaps the start of the sync word; only the true sync may match.
        for (int i = 3; i >= 0; i--) drive_bit(pre[i], 1'b1);
        send_frame(1); observe(0);
        checks++;
        if ({o_d1, o_e1, o_d2, o_e2, o_code} !== {2'b00, ok, !ok, code} || o_cfg !== flat_cur()) begin
            errors++;
            $display("FAIL gaps d1,e1,d2,e2,code=%b cfg=%h required %b %h", {o_d1, o_e1, o_d2, o_e2, o_code}, o_cfg, {2'b00, ok, !ok, code}, flat_cur());
        end
    endtask

    task automatic test_abort();
        bit ok; logic [1:0] code;
        bit seen_err = 1'b0;
        for (int k = 0; k < 18; k++) ent[k] = rand_legal();
        ent[3] = 6'b011_001;
        cks = xor_all();
        send_head(0, 50);
        @(negedge clk);
        bus_if.cfg_abort = 1'b1; bus_if.cfg_valid = 1'b1; bus_if.cfg_din = 1'($urandom);
        @(negedge clk);
        bus_if.cfg_abort = 1'b0; bus_if.cfg_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus_if.err || bus_if.done || bus_if.busy) seen_err = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen_err) begin
            errors++;
            $display("FAIL abort_quiet busy/done/err seen after abort, required none");
        end
        predict(ok, code);
        send_frame(0); observe(0);
        checks++;
        if ({o_d2, o_e2, o_code} !== {ok, !ok, code} || o_cfg !== flat_cur()) begin
            errors++;
            $display("FAIL abort_next d,e,code=%b cfg=%h required %b %h", {o_d2, o_e2, o_code}, o_cfg, {ok, !ok, code}, flat_cur());
        end
    endtask

    task automatic test_rst_midframe();
        for (int k = 0; k < 18; k++) ent[k] = rand_legal();
        send_head(0, 30);
        @(negedge clk);
        rst = 1'b1; bus_if.cfg_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 18; k++) cur[k] = '0;
        @(negedge clk);
        checks++;
        if (dut_cfg() !== flat_cur() || {bus_if.busy, bus_if.done, bus_if.err, bus_if.err_code} !== 5'b0) begin
            errors++;
            $display("FAIL rst_mid cfg=%h status=%b required %h 00000", dut_cfg(), {bus_if.busy, bus_if.done, bus_if.err, bus_if.err_code}, flat_cur());
        end
    endtask

    task automatic test_random();
        bit ok; logic [1:0] code;
        bit abort_eval;
        for (int f = 0; f < 16; f++) begin
            for (int k = 0; k < 18; k++)
                ent[k] = ($urandom_range(0, 11) == 0) ? 6'($urandom) : rand_legal();
            cks = ($urandom_range(0, 3) == 0) ? 6'($urandom) : xor_all();
            abort_eval = 1'($urandom);
            predict(ok, code);
            send_frame(2); observe(abort_eval);
            checks++;
            if ({o_b1, o_d1, o_e1, o_d2, o_e2, o_d3, o_e3} !== {3'b100, ok, !ok, 2'b00} || o_code !== code || o_code3 !== code) begin
                errors++;
                $display("FAIL random_%0d status=%b code=%b hold=%b required %b %b", f, {o_b1, o_d1, o_e1, o_d2, o_e2, o_d3, o_e3}, o_code, o_code3, {3'b100, ok, !ok, 2'b00}, code);
            end
            checks++;
            if (o_cfg !== flat_cur()) begin
                errors++;
                $display("FAIL random_cfg_%0d cfg=%h required %h", f, o_cfg, flat_cur());
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_single_and_bad_cksum();
        test_range();
        test_gaps();
        test_abort();
        test_rst_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
